// File: rtl/regfile_sb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb_pkg
// Brief    : Shared CPU constants: register index width, data width, r0 id.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_sb_pkg;

    localparam int REG_W = 5;
    localparam int XLEN  = 32;

    localparam logic [REG_W-1:0] REG_ZERO = '0;

    function automatic logic is_zero_reg(input logic [REG_W-1:0] rn);
        return (rn == REG_ZERO);
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_sb_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb_if
// Brief    : Decode/write-back bundle for the register file and scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_sb_if
    import regfile_sb_pkg::*;
#(
    parameter int NREG = 32,
    parameter int W    = XLEN
);

    logic [REG_W-1:0] rna;
    logic [REG_W-1:0] rnb;
    logic             ena;
    logic             enb;
    logic [W-1:0]     qa;
    logic [W-1:0]     qb;
    logic             we;
    logic [REG_W-1:0] wn;
    logic [W-1:0]     d;
    logic             iss_v;
    logic [REG_W-1:0] iss_rd;
    logic             stall;
    logic [NREG-1:0]  pend;

    modport master (
        output rna, rnb, ena, enb, we, wn, d, iss_v, iss_rd,
        input  qa, qb, stall, pend
    );

    modport slave (
        input  rna, rnb, ena, enb, we, wn, d, iss_v, iss_rd,
        output qa, qb, stall, pend
    );

endinterface
`default_nettype wire

// File: rtl/regfile_sb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb_scoreboard
// Brief    : Pending-write bit vector with set-over-clear update and stall compare.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_sb_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int NREG = 32
) (
    input  wire logic             clk,
    input  wire logic             clrn,
    input  wire logic [REG_W-1:0] i_rna,
    input  wire logic [REG_W-1:0] i_rnb,
    input  wire logic             i_ena,
    input  wire logic             i_enb,
    input  wire logic             i_we,
    input  wire logic [REG_W-1:0] i_wn,
    input  wire logic             i_iss_v,
    input  wire logic [REG_W-1:0] i_iss_rd,
    output logic                  o_stall,
    output logic [NREG-1:0]       o_pend
);

    logic [NREG-1:0] r_pend;
    logic [NREG-1:0] w_pend_nxt;
    logic            w_haz_a;
    logic            w_haz_b;
    logic            w_stall;
    logic            w_set;

    // A same-cycle write-back of the wanted register is served by the bypass.
    assign w_haz_a = i_ena && !is_zero_reg(i_rna) && r_pend[i_rna] && !(i_we && (i_wn == i_rna));
    assign w_haz_b = i_enb && !is_zero_reg(i_rnb) && r_pend[i_rnb] && !(i_we && (i_wn == i_rnb));
    assign w_stall = w_haz_a | w_haz_b;

    assign w_set = i_iss_v && !is_zero_reg(i_iss_rd) && !w_stall;

    // Set is applied after clear so a new producer wins over the retiring one.
    always_comb begin
        w_pend_nxt = r_pend;
        if (i_we) begin
            w_pend_nxt[i_wn] = 1'b0;
        end
        if (w_set) begin
            w_pend_nxt[i_iss_rd] = 1'b1;
        end
        w_pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    assign o_stall = w_stall;
    assign o_pend  = r_pend;

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Brief    : 32x32 register file, two bypassed read ports, one write port, scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int NREG = 32,
    parameter int W    = XLEN
) (
    input  wire logic   clk,
    input  wire logic   clrn,
    regfile_sb_if.slave bus
);

    // r0 is never stored; it reads as zero through the port mux.
    logic [W-1:0] r_regs [1:NREG-1];

    logic         w_wr_en;
    logic [W-1:0] w_qa;
    logic [W-1:0] w_qb;

    assign w_wr_en = bus.we && !is_zero_reg(bus.wn);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 1; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[bus.wn] <= bus.d;
        end
    end

    assign w_qa = is_zero_reg(bus.rna)             ? '0    :
                  (bus.we && (bus.wn == bus.rna))  ? bus.d :
                                                     r_regs[bus.rna];
    assign w_qb = is_zero_reg(bus.rnb)             ? '0    :
                  (bus.we && (bus.wn == bus.rnb))  ? bus.d :
                                                     r_regs[bus.rnb];

    assign bus.qa = w_qa;
    assign bus.qb = w_qb;

    regfile_sb_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk      (clk),
        .clrn     (clrn),
        .i_rna    (bus.rna),
        .i_rnb    (bus.rnb),
        .i_ena    (bus.ena),
        .i_enb    (bus.enb),
        .i_we     (bus.we),
        .i_wn     (bus.wn),
        .i_iss_v  (bus.iss_v),
        .i_iss_rd (bus.iss_rd),
        .o_stall  (bus.stall),
        .o_pend   (bus.pend)
    );

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sb
// Brief    : Directed self-checking bench for regfile_sb.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

    logic clk;
    logic clrn;
    int   errors;
    int   checks;

    regfile_sb_if bus ();

    regfile_sb dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        bus.rna    = 5'd0;
        bus.rnb    = 5'd0;
        bus.ena    = 1'b0;
        bus.enb    = 1'b0;
        bus.we     = 1'b0;
        bus.wn     = 5'd0;
        bus.d      = 32'h0;
        bus.iss_v  = 1'b0;
        bus.iss_rd = 5'd0;
    endtask

    task automatic test_reset();
        idle();
        clrn    = 1'b0;
        bus.rna = 5'd5;
        bus.rnb = 5'd31;
        #2;
        checks++;
        if (bus.qa !== 32'h0) begin
            errors++; $display("FAIL reset_qa: got %h expected %h", bus.qa, 32'h0);
        end
        checks++;
        if (bus.qb !== 32'h0) begin
            errors++; $display("FAIL reset_qb: got %h expected %h", bus.qb, 32'h0);
        end
        checks++;
        if (bus.pend !== 32'h0) begin
            errors++; $display("FAIL reset_pend: got %h expected %h", bus.pend, 32'h0);
        end
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got %b expected 0", bus.stall);
        end
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        bus.we  = 1'b1;
        bus.wn  = 5'd0;
        bus.d   = 32'hDEADBEEF;
        bus.rna = 5'd0;
        #1;
        checks++;
        if (bus.qa !== 32'h0) begin
            errors++; $display("FAIL r0_bypass: got %h expected %h", bus.qa, 32'h0);
        end
        @(negedge clk);
        bus.we = 1'b0;
        #1;
        checks++;
        if (bus.qa !== 32'h0) begin
            errors++; $display("FAIL r0_after_write: got %h expected %h", bus.qa, 32'h0);
        end
    endtask

    task automatic test_write_bypass();
        @(negedge clk);
        idle();
        bus.we  = 1'b1;
        bus.wn  = 5'd7;
        bus.d   = 32'h12345678;
        bus.rna = 5'd7;
        bus.rnb = 5'd8;
        #1;
        checks++;
        if (bus.qa !== 32'h12345678) begin
            errors++; $display("FAIL bypass_qa: got %h expected %h", bus.qa, 32'h12345678);
        end
        checks++;
        if (bus.qb !== 32'h0) begin
            errors++; $display("FAIL bypass_other_port: got %h expected %h", bus.qb, 32'h0);
        end
        @(negedge clk);
        bus.we  = 1'b0;
        bus.d   = 32'hFFFFFFFF;
        bus.rnb = 5'd7;
        #1;
        checks++;
        if (bus.qa !== 32'h12345678) begin
            errors++; $display("FAIL array_qa: got %h expected %h", bus.qa, 32'h12345678);
        end
        checks++;
        if (bus.qb !== 32'h12345678) begin
            errors++; $display("FAIL array_qb: got %h expected %h", bus.qb, 32'h12345678);
        end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        idle();
        bus.iss_v  = 1'b1;
        bus.iss_rd = 5'd9;
        @(negedge clk);
        idle();
        bus.rna = 5'd9;
        bus.ena = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            errors++; $display("FAIL loaduse_stall: got %b expected 1", bus.stall);
        end
        checks++;
        if (bus.pend[9] !== 1'b1) begin
            errors++; $display("FAIL loaduse_pend_set: got %b expected 1", bus.pend[9]);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            errors++; $display("FAIL loaduse_stall_hold: got %b expected 1", bus.stall);
        end
        @(negedge clk);
        bus.we = 1'b1;
        bus.wn = 5'd9;
        bus.d  = 32'hA5A5A5A5;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++; $display("FAIL wb_stall_release: got %b expected 0", bus.stall);
        end
        checks++;
        if (bus.qa !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL wb_bypass_qa: got %h expected %h", bus.qa, 32'hA5A5A5A5);
        end
        @(negedge clk);
        bus.we = 1'b0;
        #1;
        checks++;
        if (bus.pend[9] !== 1'b0) begin
            errors++; $display("FAIL wb_pend_clear: got %b expected 0", bus.pend[9]);
        end
        checks++;
        if (bus.qa !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL wb_array_qa: got %h expected %h", bus.qa, 32'hA5A5A5A5);
        end
    endtask

    task automatic test_unused_operand();
        @(negedge clk);
        idle();
        bus.iss_v  = 1'b1;
        bus.iss_rd = 5'd4;
        @(negedge clk);
        idle();
        bus.rnb = 5'd4;
        bus.enb = 1'b0;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++; $display("FAIL unused_no_stall: got %b expected 0", bus.stall);
        end
        bus.enb = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            errors++; $display("FAIL used_stall: got %b expected 1", bus.stall);
        end
        @(negedge clk);
        bus.we = 1'b1;
        bus.wn = 5'd4;
        bus.d  = 32'h44;
        #1;
        checks++;
        if (bus.qb !== 32'h44) begin
            errors++; $display("FAIL portb_bypass: got %h expected %h", bus.qb, 32'h44);
        end
    endtask

    task automatic test_collision_gating();
        @(negedge clk);
        idle();
        bus.we     = 1'b1;
        bus.wn     = 5'd3;
        bus.d      = 32'h33;
        bus.iss_v  = 1'b1;
        bus.iss_rd = 5'd3;
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (bus.pend[3] !== 1'b1) begin
            errors++; $display("FAIL collision_set_wins: got %b expected 1", bus.pend[3]);
        end
        bus.rna    = 5'd3;
        bus.ena    = 1'b1;
        bus.iss_v  = 1'b1;
        bus.iss_rd = 5'd6;
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            errors++; $display("FAIL gating_stall: got %b expected 1", bus.stall);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (bus.pend[6] !== 1'b0) begin
            errors++; $display("FAIL gated_issue: got %b expected 0", bus.pend[6]);
        end
        bus.iss_v  = 1'b1;
        bus.iss_rd = 5'd0;
        bus.we     = 1'b1;
        bus.wn     = 5'd3;
        bus.d      = 32'h3;
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (bus.pend !== 32'h0) begin
            errors++; $display("FAIL r0_issue_and_clear: got %h expected %h", bus.pend, 32'h0);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        idle();
        bus.we = 1'b1;
        bus.wn = 5'd9;
        bus.d  = 32'h11;
        @(negedge clk);
        idle();
        bus.iss_v  = 1'b1;
        bus.iss_rd = 5'd9;
        @(negedge clk);
        idle();
        bus.rna = 5'd9;
        #1;
        checks++;
        if (bus.pend[9] !== 1'b1 || bus.qa !== 32'h11) begin
            errors++; $display("FAIL pre_reset_state: got pend9=%b qa=%h expected pend9=1 qa=%h",
                               bus.pend[9], bus.qa, 32'h11);
        end
        #1;
        clrn = 1'b0;
        #1;
        checks++;
        if (bus.pend !== 32'h0) begin
            errors++; $display("FAIL async_pend_clear: got %h expected %h", bus.pend, 32'h0);
        end
        checks++;
        if (bus.qa !== 32'h0) begin
            errors++; $display("FAIL async_reg_clear: got %h expected %h", bus.qa, 32'h0);
        end
        #1;
        clrn = 1'b1;
        @(negedge clk);
        bus.we = 1'b1;
        bus.wn = 5'd9;
        bus.d  = 32'h22;
        @(negedge clk);
        bus.we = 1'b0;
        #1;
        checks++;
        if (bus.qa !== 32'h22 || bus.pend !== 32'h0) begin
            errors++; $display("FAIL late_writeback: got qa=%h pend=%h expected qa=%h pend=%h",
                               bus.qa, bus.pend, 32'h22, 32'h0);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        clrn   = 1'b1;
        idle();
        test_reset();
        test_write_bypass();
        test_load_use();
        test_unused_operand();
        test_collision_gating();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
